// File: rtl/seq_pkg.sv
// Shared definitions for the count-stream checker.
// State encoding and default data width.
package seq_pkg;

    localparam int WIDTH_DEF = 2;

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Holds at all-ones once reached.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // count enabled events, stick at the top value
    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/seq_check2bit.sv
// Receive-side checker for a gated up-count stream.
// Hunts, syncs, locks, and flags mismatches and wraps.
module seq_check2bit
    import seq_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int LOCK_CNT = 3,
    parameter int ERR_MAX  = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q,
    input  logic             show,
    input  logic             stop,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);
    localparam logic [3:0] ERR_LAST  = 4'(ERR_MAX - 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state, state_n;
    logic [WIDTH-1:0] prev, prev_n;
    logic [3:0]       good_cnt, good_n;
    logic [3:0]       bad_cnt, bad_n;
    logic             err_n, wrap_n, inc;
    logic [WIDTH-1:0] exp_q;
    logic             match;

    // expected next sample and comparison
    always_comb begin
        exp_q = stop ? prev : prev + ONE;
        match = (q == exp_q);
    end

    // next-state, reference and pulse decisions
    always_comb begin
        state_n = state;
        prev_n  = prev;
        good_n  = good_cnt;
        bad_n   = bad_cnt;
        err_n   = 1'b0;
        wrap_n  = 1'b0;
        inc     = 1'b0;
        case (state)
            HUNT: begin
                if (show) begin
                    prev_n  = q;
                    good_n  = '0;
                    state_n = SYNC;
                end
            end
            SYNC: begin
                if (show) begin
                    prev_n = q;
                    if (match) begin
                        if (good_cnt == LOCK_LAST) begin
                            good_n  = '0;
                            bad_n   = '0;
                            state_n = LOCKED;
                        end else begin
                            good_n = good_cnt + 4'd1;
                        end
                    end else begin
                        good_n = '0;
                    end
                end
            end
            LOCKED: begin
                if (show) begin
                    prev_n = q;
                    if (match) begin
                        bad_n  = '0;
                        wrap_n = !stop && (prev == '1) && (q == '0);
                    end else begin
                        err_n = 1'b1;
                        inc   = 1'b1;
                        if (bad_cnt == ERR_LAST) begin
                            bad_n   = '0;
                            state_n = HUNT;
                        end else begin
                            bad_n = bad_cnt + 4'd1;
                        end
                    end
                end
            end
            default: begin
                state_n = HUNT;
                good_n  = '0;
                bad_n   = '0;
            end
        endcase
    end

    // register FSM state, reference sample and outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= HUNT;
            prev     <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_n;
            prev     <= prev_n;
            good_cnt <= good_n;
            bad_cnt  <= bad_n;
            locked   <= (state_n == LOCKED);
            err      <= err_n;
            wrap     <= wrap_n;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk(clk),
        .clr(reset),
        .en (inc),
        .cnt(err_cnt)
    );

endmodule

// File: tb/tb_seq_check2bit.sv
// Scoreboard bench for seq_check2bit.
// Two instances share stimulus: default and 2-bit error counter.
module tb_seq_check2bit;

    logic       clk;
    logic       reset;
    logic [1:0] q;
    logic       show;
    logic       stop;
    logic       locked, err, wrap;
    logic [7:0] err_cnt;
    logic       locked2, err2, wrap2;
    logic [1:0] err_cnt2;

    seq_check2bit dut (
        .clk(clk), .reset(reset), .q(q), .show(show), .stop(stop),
        .locked(locked), .err(err), .wrap(wrap), .err_cnt(err_cnt)
    );

    seq_check2bit #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .q(q), .show(show), .stop(stop),
        .locked(locked2), .err(err2), .wrap(wrap2), .err_cnt(err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit l;
        bit e;
        bit w;
        int c;
        int c2;
    } exp_t;

    exp_t sbq[$];
    int n_chk = 0;
    int n_fail = 0;

    // reference model state: abstract view of the stream
    bit m_have;   // a reference sample exists
    bit m_lock;
    int m_prev;
    int m_run;    // consecutive good samples while syncing
    int m_miss;   // consecutive bad samples while locked
    int m_cnt;
    int m_cnt2;

    function automatic exp_t model(bit r, bit s, bit st, int qq);
        exp_t e;
        int want;
        e.e = 0;
        e.w = 0;
        if (!r) begin
            m_have = 0; m_lock = 0; m_prev = 0;
            m_run = 0; m_miss = 0; m_cnt = 0; m_cnt2 = 0;
        end else if (s) begin
            want = st ? m_prev : (m_prev + 1) % 4;
            if (!m_have) begin
                m_have = 1;
                m_run = 0;
            end else if (!m_lock) begin
                if (qq == want) begin
                    m_run++;
                    if (m_run == 3) begin
                        m_lock = 1;
                        m_run = 0;
                        m_miss = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
                if (qq == want) begin
                    m_miss = 0;
                    e.w = (!st && m_prev == 3 && qq == 0);
                end else begin
                    e.e = 1;
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                    m_miss++;
                    if (m_miss == 2) begin
                        m_lock = 0;
                        m_have = 0;
                        m_miss = 0;
                    end
                end
            end
            m_prev = qq;
        end
        e.l = m_lock;
        e.c = m_cnt;
        e.c2 = m_cnt2;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d",
                     nm, $time, act, req);
        end
    endtask

    // monitor: compare registered outputs just after each edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("locked", int'(locked), int'(e.l));
            chk("err", int'(err), int'(e.e));
            chk("wrap", int'(wrap), int'(e.w));
            chk("err_cnt", int'(err_cnt), e.c);
            chk("err_cnt_sat", int'(err_cnt2), e.c2);
            chk("locked_w2", int'(locked2), int'(e.l));
        end
    end

    task automatic step(input bit r, input bit s, input bit st,
                        input int qq);
        @(negedge clk);
        reset = r;
        show  = s;
        stop  = st;
        q     = 2'(qq);
        sbq.push_back(model(r, s, st, qq));
    endtask

    // correct next value given current model reference
    function automatic int nxt(bit st);
        return st ? m_prev : (m_prev + 1) % 4;
    endfunction

    initial begin
        reset = 0; show = 0; stop = 0; q = 0;
        m_have = 0; m_lock = 0; m_prev = 0;
        m_run = 0; m_miss = 0; m_cnt = 0; m_cnt2 = 0;

        step(0, 0, 0, 0);
        step(0, 1, 0, 2);
        // acquire lock on 0..3, then wrap
        for (int i = 0; i < 4; i++) step(1, 1, 0, i);
        step(1, 1, 0, 0);
        step(1, 1, 0, 1);
        step(1, 1, 0, 2);
        // held value for three cycles
        for (int i = 0; i < 3; i++) step(1, 1, 1, 2);
        step(1, 1, 0, 3);
        // wrap sample colliding with a mismatch
        step(1, 1, 0, 1);
        step(1, 1, 0, 3);
        // gapped stream relocks
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, i % 4);
            step(1, 0, 0, 3);
        end
        // isolated errors while locked, saturating the narrow counter
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, (m_prev + 2) % 4);
            step(1, 1, 0, nxt(0));
        end
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, s, st;
            int qq;
            r  = ($urandom_range(199) != 0);
            s  = ($urandom_range(3) != 0);
            st = ($urandom_range(3) == 0);
            if ($urandom_range(9) < 8) qq = nxt(st);
            else qq = int'($urandom_range(3));
            step(r, s, st, qq);
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
